// File: rtl/coupled_cell_sync.sv
// Purpose: re-times synchronised din edges onto dout after a weighted, per-source delay.
// Latency: dout follows a detected edge delay+1 cycles later, plus SYNC_STAGES+1 from the din pin.
// Backpressure: none upstream; when the edge FIFO is full, new edges merge into the tail entry.
//
// Ports:
//   clk, axi_rst          clock and asynchronous active-high reset
//   ising_rstn            0 = spin programming: FIFO flushed, dout follows din_s
//   din, sout[NUM_SRC]    asynchronous phase inputs (upstream cell, coupled sources)
//   dout                  registered re-timed phase
//   wready, wr_addr_match write strobe and cell select; wdata carries packed weight fields
//   rdata                 {ovf_cnt[7:0], zeros, packed weights}
module coupled_cell_sync #(
    parameter int NUM_SRC     = 1,
    parameter int NUM_WEIGHTS = 15,
    parameter int WEIGHT_W    = 4,
    parameter int BASE_DELAY  = 2,
    parameter int EDGE_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               axi_rst,
    input  logic               ising_rstn,
    input  logic               din,
    input  logic [NUM_SRC-1:0] sout,
    output logic               dout,
    input  logic               wready,
    input  logic               wr_addr_match,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata
);
    localparam int WMAX  = NUM_WEIGHTS - 1;
    localparam int WINIT = (NUM_WEIGHTS - 1) / 2;
    localparam int DW    = $clog2(BASE_DELAY + NUM_SRC * WMAX + 1);
    localparam int PW    = (EDGE_DEPTH > 1) ? $clog2(EDGE_DEPTH) : 1;
    localparam int CW    = $clog2(EDGE_DEPTH + 1);

    // Synchronisers and edge detect
    logic [SYNC_STAGES-1:0] din_sync_q;
    logic [NUM_SRC-1:0]     sout_sync_q [SYNC_STAGES];
    logic                   din_s, din_q;
    logic [NUM_SRC-1:0]     sout_s;

    // Weights
    logic [WEIGHT_W-1:0] weight_q [NUM_SRC];
    logic [WEIGHT_W-1:0] weight_d [NUM_SRC];

    // Pending-edge FIFO and head countdown
    logic            lvl_q [EDGE_DEPTH];
    logic            lvl_d [EDGE_DEPTH];
    logic [DW-1:0]   dly_q [EDGE_DEPTH];
    logic [DW-1:0]   dly_d [EDGE_DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, tail_ptr;
    logic [CW-1:0]   occ_q, occ_d;
    logic            head_vld_q, head_vld_d;
    logic [DW-1:0]   timer_q, timer_d;
    logic            dout_q, dout_d;
    logic [7:0]      ovf_q, ovf_d;

    logic            detect, pop, full, push, coalesce, load;
    logic [DW-1:0]   delay_sum, term;
    logic            wdata_unused;

    assign wdata_unused = ^wdata;
    assign din_s  = din_sync_q[SYNC_STAGES-1];
    assign sout_s = sout_sync_q[SYNC_STAGES-1];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(EDGE_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Field writes saturate at WMAX rather than wrapping.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            weight_d[i] = weight_q[i];
            if (wready && wr_addr_match) begin
                if (wdata[i*WEIGHT_W +: WEIGHT_W] > WEIGHT_W'(WMAX))
                    weight_d[i] = WEIGHT_W'(WMAX);
                else
                    weight_d[i] = wdata[i*WEIGHT_W +: WEIGHT_W];
            end
        end
    end

    // A source out of phase with the new level contributes its weight, an
    // in-phase source contributes the complement.
    always_comb begin
        delay_sum = DW'(BASE_DELAY);
        term      = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            term = (din_s != sout_s[i]) ? DW'(weight_q[i]) : DW'(WMAX) - DW'(weight_q[i]);
            delay_sum = delay_sum + term;
        end
    end

    assign detect   = ising_rstn && (din_s != din_q);
    assign pop      = ising_rstn && head_vld_q && (timer_q == DW'(1));
    assign full     = (occ_q == CW'(EDGE_DEPTH));
    assign push     = detect && (!full || pop);
    assign coalesce = detect && full && !pop;
    assign load     = ising_rstn && !head_vld_q && (occ_q != '0);
    assign tail_ptr = (wr_ptr_q == '0) ? PW'(EDGE_DEPTH - 1) : wr_ptr_q - 1'b1;

    always_comb begin
        lvl_d      = lvl_q;
        dly_d      = dly_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        occ_d      = occ_q;
        head_vld_d = head_vld_q;
        timer_d    = timer_q;
        dout_d     = dout_q;
        ovf_d      = ovf_q;
        if (!ising_rstn) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            occ_d      = '0;
            head_vld_d = 1'b0;
            timer_d    = '0;
            dout_d     = din_s;
        end else begin
            // Head entry: load its delay once, count down, release at zero.
            if (load) begin
                head_vld_d = 1'b1;
                timer_d    = dly_q[rd_ptr_q];
            end else if (head_vld_q) begin
                timer_d = timer_q - 1'b1;
                if (pop) begin
                    dout_d     = lvl_q[rd_ptr_q];
                    head_vld_d = 1'b0;
                    rd_ptr_d   = ptr_inc(rd_ptr_q);
                end
            end
            // When full, the tail keeps its delay but adopts the newest level,
            // so the two edges collapse into one and dout still ends on din_s.
            if (push) begin
                lvl_d[wr_ptr_q] = din_s;
                dly_d[wr_ptr_q] = delay_sum;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end else if (coalesce) begin
                lvl_d[tail_ptr] = din_s;
                if (ovf_q != 8'hFF)
                    ovf_d = ovf_q + 8'd1;
            end
            if (push && !pop)
                occ_d = occ_q + 1'b1;
            else if (pop && !push)
                occ_d = occ_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge axi_rst) begin
        if (axi_rst) begin
            din_sync_q <= '0;
            for (int s = 0; s < SYNC_STAGES; s++) sout_sync_q[s] <= '0;
            din_q <= 1'b0;
            for (int i = 0; i < NUM_SRC; i++) weight_q[i] <= WEIGHT_W'(WINIT);
            for (int e = 0; e < EDGE_DEPTH; e++) begin
                lvl_q[e] <= 1'b0;
                dly_q[e] <= '0;
            end
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            occ_q      <= '0;
            head_vld_q <= 1'b0;
            timer_q    <= '0;
            dout_q     <= 1'b0;
            ovf_q      <= '0;
        end else begin
            din_sync_q[0]  <= din;
            sout_sync_q[0] <= sout;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                din_sync_q[s]  <= din_sync_q[s-1];
                sout_sync_q[s] <= sout_sync_q[s-1];
            end
            // Always tracking din_s means leaving spin programming never sees a stale edge.
            din_q      <= din_s;
            weight_q   <= weight_d;
            lvl_q      <= lvl_d;
            dly_q      <= dly_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            occ_q      <= occ_d;
            head_vld_q <= head_vld_d;
            timer_q    <= timer_d;
            dout_q     <= dout_d;
            ovf_q      <= ovf_d;
        end
    end

    assign dout = dout_q;

    always_comb begin
        rdata        = '0;
        rdata[31:24] = ovf_q;
        for (int i = 0; i < NUM_SRC; i++)
            rdata[i*WEIGHT_W +: WEIGHT_W] = weight_q[i];
    end

endmodule

// File: tb/tb_coupled_cell_sync.sv
// Purpose: scoreboard bench for coupled_cell_sync; a one-source and a two-source instance.
// Latency: expected dout changes carry the exact cycle they are due on.
// Backpressure: n/a (bench).
module tb_coupled_cell_sync;
    logic        clk = 1'b0;
    logic        axi_rst, ising_rstn, din, din2, wready, sel1, sel2;
    logic [0:0]  sout;
    logic [1:0]  sout2;
    logic [31:0] wdata, rdata, rdata2;
    logic        dout, dout2;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic lvl;
        int   cyc;
    } exp_t;
    exp_t sb1[$];
    exp_t sb2[$];

    coupled_cell_sync u1 (
        .clk(clk), .axi_rst(axi_rst), .ising_rstn(ising_rstn), .din(din), .sout(sout),
        .dout(dout), .wready(wready), .wr_addr_match(sel1), .wdata(wdata), .rdata(rdata)
    );

    coupled_cell_sync #(.NUM_SRC(2)) u2 (
        .clk(clk), .axi_rst(axi_rst), .ising_rstn(ising_rstn), .din(din2), .sout(sout2),
        .dout(dout2), .wready(wready), .wr_addr_match(sel2), .wdata(wdata), .rdata(rdata2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int which, input logic [31:0] data);
        tick(1);
        wdata  = data;
        wready = 1'b1;
        sel1   = (which == 1);
        sel2   = (which == 2);
        tick(1);
        wready = 1'b0;
        sel1   = 1'b0;
        sel2   = 1'b0;
    endtask

    // Every dout change must match the oldest expectation in level and cycle.
    logic d1_prev = 1'b0;
    logic d2_prev = 1'b0;
    always @(negedge clk) begin
        if (mon_en && dout !== d1_prev) begin
            if (sb1.size() == 0) begin
                check("u1_spurious", 32'(dout), 32'(d1_prev));
            end else begin
                exp_t e;
                e = sb1.pop_front();
                check("u1_lvl", 32'(dout), 32'(e.lvl));
                check("u1_cyc", 32'(cyc), 32'(e.cyc));
            end
        end
        d1_prev = dout;
    end

    always @(negedge clk) begin
        if (mon_en && dout2 !== d2_prev) begin
            if (sb2.size() == 0) begin
                check("u2_spurious", 32'(dout2), 32'(d2_prev));
            end else begin
                exp_t e;
                e = sb2.pop_front();
                check("u2_lvl", 32'(dout2), 32'(e.lvl));
                check("u2_cyc", 32'(cyc), 32'(e.cyc));
            end
        end
        d2_prev = dout2;
    end

    initial begin
        int   c0;
        logic s;
        axi_rst = 1'b1; ising_rstn = 1'b1; din = 1'b0; din2 = 1'b0;
        sout = 1'b0; sout2 = 2'b10; wready = 1'b0; sel1 = 1'b0; sel2 = 1'b0; wdata = '0;
        tick(3);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_dout2", 32'(dout2), 32'd0);
        check("rst_rdata", rdata, 32'h0000_0007);
        check("rst_rdata2", rdata2, 32'h0000_0077);
        @(negedge clk);
        axi_rst = 1'b0;
        mon_en  = 1'b1;
        tick(5);

        // Default weight 7, mismatch: delay 9, dout moves 4+9 cycles after the drive
        tick(1); din = 1'b1; sb1.push_back('{1'b1, cyc + 13});
        tick(20);
        check("t1_dout", 32'(dout), 32'd1);
        // Falling edge against sout=0 is a match: 14-7 = 7, delay 9 again
        tick(1); din = 1'b0; sb1.push_back('{1'b0, cyc + 13});
        tick(20);

        // Weight 3, sout=1
        wr(1, 32'h3);
        check("t2_rdata3", rdata, 32'h0000_0003);
        sout = 1'b1;
        tick(4);
        tick(1); din = 1'b1; sb1.push_back('{1'b1, cyc + 17});  // match: 2+11
        tick(24);
        tick(1); din = 1'b0; sb1.push_back('{1'b0, cyc + 9});   // mismatch: 2+3
        tick(14);
        wr(1, 32'h1F);
        check("t2_sat", rdata, 32'h0000_000E);
        tick(1); din = 1'b1; sb1.push_back('{1'b1, cyc + 6});   // match at WMAX: delay 2
        tick(10);
        wr(1, 32'h7);
        check("t2_rdata7", rdata, 32'h0000_0007);
        tick(3);

        // Burst of six edges one cycle apart into a 4-deep FIFO, delay 9
        s = din;
        tick(1);
        c0 = cyc;
        for (int k = 0; k < 4; k++)
            sb1.push_back('{(k % 2 == 0) ? ~s : s, c0 + 13 + 10 * k});
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick(1);
            din = ~din;
        end
        tick(50);
        check("t3_ovf", 32'(rdata[31:24]), 32'd2);
        check("t3_final", 32'(dout), 32'(s));
        check("t3_sb_empty", 32'(sb1.size()), 32'd0);

        // Three edges queued, then spin programming
        tick(1); din = ~din;
        tick(1); din = ~din;
        tick(1); din = ~din;
        tick(4);
        ising_rstn = 1'b0;
        sb1.push_back('{din, cyc + 1});
        tick(2);
        din = ~din;
        sb1.push_back('{din, cyc + 3});
        tick(6);
        check("t4_track", 32'(dout), 32'(din));
        ising_rstn = 1'b1;
        tick(30);
        check("t4_idle", 32'(dout), 32'(din));
        check("t4_sb_empty", 32'(sb1.size()), 32'd0);
        check("t4_ovf_kept", 32'(rdata[31:24]), 32'd2);

        // Reset in the middle of a countdown, no clock edge before the checks
        wr(1, 32'h3);
        check("t5_pre_rdata", rdata, 32'h0200_0003);
        tick(1); din = 1'b0;
        tick(4);
        #3;
        mon_en  = 1'b0;
        axi_rst = 1'b1;
        #1;
        check("t5_dout", 32'(dout), 32'd0);
        check("t5_rdata", rdata, 32'h0000_0007);
        tick(2);
        @(negedge clk);
        axi_rst = 1'b0;
        #1;
        mon_en = 1'b1;
        tick(20);
        check("t5_quiet", 32'(dout), 32'd0);

        // Two sources: w0=14, w1=14, sout0=0 (mismatch), sout1=1 (match): 2+14+0 = 16
        wr(2, 32'hEE);
        check("t6_rdata2", rdata2, 32'h0000_00EE);
        tick(1); din2 = 1'b1; sb2.push_back('{1'b1, cyc + 20});
        tick(25);
        check("t6_dout2", 32'(dout2), 32'd1);
        // w1=5: falling edge, src0 match (0) + src1 mismatch (5): delay 7
        wr(2, 32'h5E);
        tick(1); din2 = 1'b0; sb2.push_back('{1'b0, cyc + 11});
        tick(15);
        check("t6_dout2_fall", 32'(dout2), 32'd0);
        check("t6_dout1_quiet", 32'(dout), 32'd0);

        check("end_sb1", 32'(sb1.size()), 32'd0);
        check("end_sb2", 32'(sb2.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
